eagle_base: RTL and testbench

Parametrised player-base target for the tank playfield, the next generation of the single-hit eagle. It tracks up to N bullets at once, carries a hit-point budget with post-hit invulnerability, and runs an explosion sequence before latching destruction. It sits beside the tank and enemy modules, feeds the pixel mux via `base_on` and the sprite address, and feeds game-over logic via `destroyed`.

---
 rtl/tank_game_pkg.sv | 15 +
 rtl/box_overlap.sv | 32 +++
 rtl/eagle_base.sv | 150 +++++++++++++++
 tb/tb_eagle_base.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tank_game_pkg.sv
// Shared types and constants for the tank playfield blocks.
package tank_game_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef enum logic [1:0] {
    ALIVE,
    COOLDOWN,
    EXPLODING,
    DESTROYED
  } base_state_t;

endpackage

// File: rtl/box_overlap.sv
// Strict axis-aligned overlap test between a fixed-size box A and a bullet box B.
module box_overlap
  import tank_game_pkg::*;
#(
  parameter int unsigned ASize = 32,
  parameter int unsigned BSize = 4
) (
  input  logic [COORD_W-1:0] a_x_i,
  input  logic [COORD_W-1:0] a_y_i,
  input  logic [COORD_W-1:0] b_x_i,
  input  logic [COORD_W-1:0] b_y_i,
  input  logic               b_valid_i,
  output logic               overlap_o
);

  localparam int unsigned SumW = COORD_W + 1;

  // One extra bit keeps far-right/bottom edges from wrapping past 1023.
  logic [SumW-1:0] ax, ay, bx, by;

  assign ax = {1'b0, a_x_i};
  assign ay = {1'b0, a_y_i};
  assign bx = {1'b0, b_x_i};
  assign by = {1'b0, b_y_i};

  assign overlap_o = b_valid_i
                     && (bx < ax + SumW'(ASize))
                     && (bx + SumW'(BSize) > ax)
                     && (by < ay + SumW'(ASize))
                     && (by + SumW'(BSize) > ay);

endmodule

// File: rtl/eagle_base.sv
// Player base: multi-bullet hit detection, hit points with invulnerability,
// explosion sequence and registered sprite addressing for the pixel mux.
module eagle_base
  import tank_game_pkg::*;
#(
  parameter int unsigned X_POS           = 320,
  parameter int unsigned Y_POS           = 240,
  parameter int unsigned SIZE            = 32,
  parameter int unsigned N_BULLETS       = 2,
  parameter int unsigned BULLET_SIZE     = 4,
  parameter int unsigned HP_MAX          = 3,
  parameter int unsigned COOLDOWN_FRAMES = 32,
  parameter int unsigned EXPLODE_FRAMES  = 16
) (
  input  logic                      clk_50MHz,
  input  logic                      reset,
  input  logic [9:0]                x,
  input  logic [9:0]                y,
  input  logic                      refresh_tick,
  input  logic [10*N_BULLETS-1:0]   bullet_x,
  input  logic [10*N_BULLETS-1:0]   bullet_y,
  input  logic [N_BULLETS-1:0]      bullet_valid,
  output logic [N_BULLETS-1:0]      hit_ack,
  output logic                      base_on,
  output logic [$clog2(SIZE)-1:0]   sprite_row,
  output logic [$clog2(SIZE)-1:0]   sprite_col,
  output logic                      sprite_sel,
  output logic [3:0]                explode_frame,
  output logic [3:0]                hp,
  output logic                      destroyed
);

  localparam int unsigned SprW = $clog2(SIZE);
  localparam int unsigned CntW = 16;

  base_state_t          state_q, state_d;
  logic [3:0]           hp_q, hp_d;
  logic [CntW-1:0]      cd_q, cd_d;
  logic [CntW-1:0]      fc_q, fc_d;
  logic [N_BULLETS-1:0] overlap;
  logic [N_BULLETS-1:0] ack_q, ack_d;

  for (genvar i = 0; i < N_BULLETS; i++) begin : g_chan
    box_overlap #(
      .ASize(SIZE),
      .BSize(BULLET_SIZE)
    ) u_overlap (
      .a_x_i    (COORD_W'(X_POS)),
      .a_y_i    (COORD_W'(Y_POS)),
      .b_x_i    (bullet_x[10*i +: 10]),
      .b_y_i    (bullet_y[10*i +: 10]),
      .b_valid_i(bullet_valid[i]),
      .overlap_o(overlap[i])
    );
  end

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cd_d    = cd_q;
    fc_d    = fc_q;
    ack_d   = '0;
    if (refresh_tick) begin
      case (state_q)
        ALIVE: begin
          ack_d = overlap;
          if (|overlap) begin
            // A frame costs at most one hit point however many bullets land.
            hp_d = hp_q - 4'd1;
            if (hp_d == 4'd0) begin
              state_d = EXPLODING;
              fc_d    = '0;
            end else begin
              state_d = COOLDOWN;
              cd_d    = CntW'(COOLDOWN_FRAMES - 1);
            end
          end
        end
        COOLDOWN: begin
          ack_d = overlap;
          if (cd_q == '0) begin
            state_d = ALIVE;
          end else begin
            cd_d = cd_q - CntW'(1);
          end
        end
        EXPLODING: begin
          if (fc_q == CntW'(EXPLODE_FRAMES - 1)) begin
            state_d = DESTROYED;
          end else begin
            fc_d = fc_q + CntW'(1);
          end
        end
        DESTROYED: ;
        default: state_d = ALIVE;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q <= ALIVE;
      hp_q    <= 4'(HP_MAX);
      cd_q    <= '0;
      fc_q    <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cd_q    <= cd_d;
      fc_q    <= fc_d;
      ack_q   <= ack_d;
    end
  end

  // Pixel path: unsigned 10-bit differences reject pixels left of / above the box.
  logic [COORD_W-1:0] dx, dy;
  logic               in_box;
  logic               base_on_q, sprite_sel_q;
  logic [SprW-1:0]    sprite_row_q, sprite_col_q;

  assign dx     = x - COORD_W'(X_POS);
  assign dy     = y - COORD_W'(Y_POS);
  assign in_box = (dx < COORD_W'(SIZE)) && (dy < COORD_W'(SIZE));

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      base_on_q    <= 1'b0;
      sprite_sel_q <= 1'b0;
      sprite_row_q <= '0;
      sprite_col_q <= '0;
    end else begin
      // Counter bit 2 blanks the sprite every other 4 frames while invulnerable.
      base_on_q    <= in_box && (state_q != DESTROYED) && !((state_q == COOLDOWN) && cd_q[2]);
      sprite_sel_q <= (state_q == EXPLODING);
      sprite_row_q <= dy[SprW-1:0];
      sprite_col_q <= dx[SprW-1:0];
    end
  end

  assign hit_ack       = ack_q;
  assign hp            = hp_q;
  assign destroyed     = (state_q == DESTROYED);
  assign explode_frame = 4'((32'(fc_q) * 32'd16) / 32'(EXPLODE_FRAMES));
  assign base_on       = base_on_q;
  assign sprite_sel    = sprite_sel_q;
  assign sprite_row    = sprite_row_q;
  assign sprite_col    = sprite_col_q;

endmodule

// File: tb/tb_eagle_base.sv
// Scoreboard bench for eagle_base: stimulus pushes expectations, a monitor checks them.
`timescale 1ns/1ps
module tb_eagle_base;

  logic        clk_50MHz = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic        refresh_tick;
  logic [19:0] bullet_x, bullet_y;
  logic [1:0]  bullet_valid;
  logic [1:0]  hit_ack;
  logic        base_on;
  logic [4:0]  sprite_row, sprite_col;
  logic        sprite_sel;
  logic [3:0]  explode_frame, hp;
  logic        destroyed;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      nm;
    logic [1:0] ack;
    logic [3:0] hp;
    logic       dest;
    logic [3:0] ef;
    logic       is_rst;
    logic       on;
    logic       sel;
  } exp_t;

  exp_t sb_q[$];

  eagle_base dut (
    .clk_50MHz    (clk_50MHz),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .refresh_tick (refresh_tick),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .bullet_valid (bullet_valid),
    .hit_ack      (hit_ack),
    .base_on      (base_on),
    .sprite_row   (sprite_row),
    .sprite_col   (sprite_col),
    .sprite_sel   (sprite_sel),
    .explode_frame(explode_frame),
    .hp           (hp),
    .destroyed    (destroyed)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: one response per tick/reset cycle, then the registered pixel view a cycle later.
  always begin
    exp_t e;
    @(posedge clk_50MHz);
    if (refresh_tick || reset) begin
      #1;
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_empty: got response with no expectation queued");
      end else begin
        e = sb_q.pop_front();
        chk({e.nm, ".hit_ack"}, 32'(hit_ack), 32'(e.ack));
        chk({e.nm, ".hp"}, 32'(hp), 32'(e.hp));
        chk({e.nm, ".destroyed"}, 32'(destroyed), 32'(e.dest));
        chk({e.nm, ".explode_frame"}, 32'(explode_frame), 32'(e.ef));
        if (e.is_rst) begin
          chk({e.nm, ".rst_base_on"}, 32'(base_on), 32'd0);
          chk({e.nm, ".rst_sprite_sel"}, 32'(sprite_sel), 32'd0);
          chk({e.nm, ".rst_sprite_row"}, 32'(sprite_row), 32'd0);
          chk({e.nm, ".rst_sprite_col"}, 32'(sprite_col), 32'd0);
        end
        @(posedge clk_50MHz);
        #1;
        chk({e.nm, ".base_on"}, 32'(base_on), 32'(e.on));
        chk({e.nm, ".sprite_sel"}, 32'(sprite_sel), 32'(e.sel));
        chk({e.nm, ".sprite_row"}, 32'(sprite_row), 32'd5);
        chk({e.nm, ".sprite_col"}, 32'(sprite_col), 32'd3);
      end
    end
  end

  task automatic tick(input string nm, input logic [1:0] v,
                      input logic [9:0] bx0, input logic [9:0] by0,
                      input logic [9:0] bx1, input logic [9:0] by1,
                      input logic [1:0] eack, input logic [3:0] ehp, input logic edest,
                      input logic [3:0] eef, input logic eon, input logic esel);
    exp_t e;
    @(negedge clk_50MHz);
    bullet_x     = {bx1, bx0};
    bullet_y     = {by1, by0};
    bullet_valid = v;
    refresh_tick = 1'b1;
    e.nm = nm; e.ack = eack; e.hp = ehp; e.dest = edest; e.ef = eef;
    e.is_rst = 1'b0; e.on = eon; e.sel = esel;
    sb_q.push_back(e);
    @(negedge clk_50MHz);
    refresh_tick = 1'b0;
    // Overlapping bullets off-tick must be ignored.
    bullet_x     = {10'd340, 10'd330};
    bullet_y     = {10'd260, 10'd250};
    bullet_valid = 2'b11;
    repeat (2) @(negedge clk_50MHz);
  endtask

  task automatic idle(input string nm, input logic [3:0] ehp, input logic edest,
                      input logic [3:0] eef, input logic eon, input logic esel);
    tick(nm, 2'b00, 10'd0, 10'd0, 10'd0, 10'd0, 2'b00, ehp, edest, eef, eon, esel);
  endtask

  task automatic do_reset(input string nm, input logic with_tick);
    exp_t e;
    @(negedge clk_50MHz);
    reset        = 1'b1;
    refresh_tick = with_tick;
    bullet_x     = {10'd340, 10'd330};
    bullet_y     = {10'd260, 10'd250};
    bullet_valid = 2'b11;
    e.nm = nm; e.ack = 2'b00; e.hp = 4'd3; e.dest = 1'b0; e.ef = 4'd0;
    e.is_rst = 1'b1; e.on = 1'b1; e.sel = 1'b0;
    sb_q.push_back(e);
    @(negedge clk_50MHz);
    reset        = 1'b0;
    refresh_tick = 1'b0;
    bullet_valid = 2'b00;
    repeat (2) @(negedge clk_50MHz);
  endtask

  // 32 ticks of invulnerability after a non-fatal hit; the sprite blinks on counter bit 2.
  task automatic cool_run(input logic [3:0] h, input int hit_at, input logic hit_last);
    int   c;
    logic eon;
    for (int j = 1; j <= 32; j++) begin
      c   = 31 - j;
      eon = (j == 32) ? 1'b1 : ~c[2];
      if (j == hit_at)
        tick("cd_hit", 2'b01, 10'd330, 10'd250, 10'd0, 10'd0, 2'b01, h, 1'b0, 4'd0, eon, 1'b0);
      else if (j == 32 && hit_last)
        tick("cd_exit_hit", 2'b01, 10'd330, 10'd250, 10'd0, 10'd0, 2'b01, h, 1'b0, 4'd0,
             eon, 1'b0);
      else
        idle("cd_idle", h, 1'b0, 4'd0, eon, 1'b0);
    end
  endtask

  task automatic hit_one(input string nm, input logic [3:0] ehp, input logic eon,
                         input logic esel);
    tick(nm, 2'b01, 10'd330, 10'd250, 10'd0, 10'd0, 2'b01, ehp, 1'b0, 4'd0, eon, esel);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    refresh_tick = 1'b0;
    x            = 10'd323;
    y            = 10'd245;
    bullet_x     = '0;
    bullet_y     = '0;
    bullet_valid = '0;
    repeat (2) @(negedge clk_50MHz);

    do_reset("reset", 1'b0);
    hit_one("single_hit", 4'd2, 1'b0, 1'b0);

    do_reset("reset2", 1'b0);
    tick("double_hit", 2'b11, 10'd330, 10'd250, 10'd340, 10'd260, 2'b11, 4'd2, 1'b0, 4'd0,
         1'b0, 1'b0);
    cool_run(4'd2, 5, 1'b1);

    tick("edge_left", 2'b01, 10'd316, 10'd250, 10'd0, 10'd0, 2'b00, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0);
    tick("edge_top", 2'b01, 10'd330, 10'd236, 10'd0, 10'd0, 2'b00, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0);
    tick("edge_right", 2'b01, 10'd352, 10'd250, 10'd0, 10'd0, 2'b00, 4'd2, 1'b0, 4'd0,
         1'b1, 1'b0);
    tick("edge_bottom", 2'b01, 10'd330, 10'd272, 10'd0, 10'd0, 2'b00, 4'd2, 1'b0, 4'd0,
         1'b1, 1'b0);
    tick("far_corner", 2'b01, 10'd1022, 10'd1022, 10'd0, 10'd0, 2'b00, 4'd2, 1'b0, 4'd0,
         1'b1, 1'b0);
    tick("not_valid", 2'b00, 10'd330, 10'd250, 10'd330, 10'd250, 2'b00, 4'd2, 1'b0, 4'd0,
         1'b1, 1'b0);
    tick("edge_left_in", 2'b01, 10'd317, 10'd250, 10'd0, 10'd0, 2'b01, 4'd1, 1'b0, 4'd0,
         1'b0, 1'b0);
    cool_run(4'd1, 0, 1'b0);

    tick("fatal_hit", 2'b10, 10'd330, 10'd250, 10'd351, 10'd271, 2'b10, 4'd0, 1'b0, 4'd0,
         1'b1, 1'b1);
    for (int k = 1; k <= 15; k++)
      tick("explode", 2'b11, 10'd330, 10'd250, 10'd340, 10'd260, 2'b00, 4'd0, 1'b0, 4'(k),
           1'b1, 1'b1);
    tick("explode_end", 2'b11, 10'd330, 10'd250, 10'd340, 10'd260, 2'b00, 4'd0, 1'b1, 4'd15,
         1'b0, 1'b0);
    tick("post_destroy", 2'b11, 10'd330, 10'd250, 10'd340, 10'd260, 2'b00, 4'd0, 1'b1, 4'd15,
         1'b0, 1'b0);

    do_reset("reset3", 1'b0);
    hit_one("kill_1", 4'd2, 1'b0, 1'b0);
    cool_run(4'd2, 0, 1'b0);
    hit_one("kill_2", 4'd1, 1'b0, 1'b0);
    cool_run(4'd1, 0, 1'b0);
    hit_one("kill_3", 4'd0, 1'b1, 1'b1);
    for (int k = 1; k <= 7; k++)
      idle("explode_mid", 4'd0, 1'b0, 4'(k), 1'b1, 1'b1);
    do_reset("reset_mid_explode", 1'b1);
    hit_one("revive_hit", 4'd2, 1'b0, 1'b0);

    repeat (4) @(negedge clk_50MHz);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
